// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder driving one single-port synchronous RAM bank.
module ahb_sram_slave #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hreadyin,
  output logic              hready,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              ram_en,
  output logic              ram_rwn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wben,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ERR1, ERR2} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        lsb_q, lsb_d;
  logic [2:0]        size_q, size_d;
  logic              accept, legal, unused_haddr;
  assign unused_haddr = ^haddr[31:ADDR_W+2];
  always_comb begin
    hready  = state_q == IDLE || state_q == WR || state_q == RD2 || state_q == ERR2;
    hresp   = state_q == ERR1 || state_q == ERR2;
    accept  = hsel && htrans[1] && hreadyin && hready;
    legal   = hsize <= 3'd2 && !(hsize == 3'd1 && haddr[0]) && !(hsize == 3'd2 && haddr[1:0] != 2'd0);
    state_d = state_q == RD1 ? RD2 : state_q == ERR1 ? ERR2 : !accept ? IDLE : !legal ? ERR1 : hwrite ? WR : RD1;
    addr_d  = accept ? haddr[ADDR_W+1:2] : addr_q;
    lsb_d   = accept ? haddr[1:0] : lsb_q;
    size_d  = accept ? hsize : size_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lsb_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lsb_q   <= lsb_d;
      size_q  <= size_d;
    end
  end
  // Strobes decode straight from the registered state so reset drops them at once.
  always_comb begin
    ram_en    = state_q == WR || state_q == RD1;
    ram_rwn   = state_q != WR;
    ram_addr  = addr_q;
    ram_wdata = state_q == WR ? hwdata : 32'd0;
    ram_wben  = state_q != WR ? 4'b0000 : size_q == 3'd0 ? 4'b0001 << lsb_q :
                size_q == 3'd1 ? (lsb_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    hrdata    = state_q == RD2 ? ram_rdata : 32'd0;
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed per-cycle vector table plus reset and stall sequences.
module tb_ahb_sram_slave;
  logic        clk = 0, resetn = 0;
  logic        hsel = 0, hwrite = 0, hreadyin = 1;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [1:0]  htrans = 0;
  logic [2:0]  hsize = 0;
  logic        hready, hresp, ram_en, ram_rwn;
  logic [31:0] hrdata, ram_wdata, ram_rdata;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wben;
  int          total = 0, bad = 0;

  ahb_sram_slave #(.ADDR_W(14)) dut (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hreadyin(hreadyin),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .ram_en(ram_en),
    .ram_rwn(ram_rwn), .ram_addr(ram_addr), .ram_wben(ram_wben),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en && !ram_rwn) begin
      for (int b = 0; b < 4; b++) if (ram_wben[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_en && ram_rwn) ram_rdata <= mem[ram_addr[7:0]];
  end

  typedef struct packed {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        e_rdy, e_resp, e_en, e_rwn;
    logic [3:0]  e_wben;
    logic [13:0] e_addr;
    logic [31:0] e_rdata, e_wdata;
  } vec_t;
  vec_t v [20];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic w, input logic [2:0] z,
                       input logic [31:0] a, input logic [31:0] d, input logic r);
    hsel = s; htrans = t; hwrite = w; hsize = z; haddr = a; hwdata = d; hreadyin = r;
  endtask

  function automatic logic [127:0] outs(input logic [13:0] a);
    return {hready, hresp, ram_en, ram_rwn, ram_wben, a, hrdata, ram_wdata};
  endfunction

  initial begin
    v[0]  = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[1]  = '{1, 2'd2, 1, 3'd2, 32'h10, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[2]  = '{1, 2'd2, 0, 3'd2, 32'h10, 32'hDEADBEEF, 1, 1, 0, 1, 0, 4'hF, 14'd4, 32'h0, 32'hDEADBEEF};
    v[3]  = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 0, 0, 1, 1, 4'h0, 14'd4, 32'h0, 32'h0};
    v[4]  = '{1, 2'd2, 1, 3'd0, 32'h13, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'hDEADBEEF, 32'h0};
    v[5]  = '{1, 2'd2, 1, 3'd1, 32'h12, 32'hAABBCCDD, 1, 1, 0, 1, 0, 4'h8, 14'd4, 32'h0, 32'hAABBCCDD};
    v[6]  = '{1, 2'd2, 1, 3'd0, 32'h10, 32'h12345678, 1, 1, 0, 1, 0, 4'hC, 14'd4, 32'h0, 32'h12345678};
    v[7]  = '{1, 2'd2, 0, 3'd2, 32'h02, 32'h000000EE, 1, 1, 0, 1, 0, 4'h1, 14'd4, 32'h0, 32'h000000EE};
    v[8]  = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 0, 1, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[9]  = '{1, 2'd2, 1, 3'd3, 32'h20, 32'h0, 1, 1, 1, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[10] = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 0, 1, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[11] = '{1, 2'd2, 1, 3'd2, 32'h40, 32'h0, 1, 1, 1, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[12] = '{1, 2'd2, 0, 3'd2, 32'h40, 32'hCAFEF00D, 1, 1, 0, 1, 0, 4'hF, 14'd16, 32'h0, 32'hCAFEF00D};
    v[13] = '{1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1, 0, 0, 1, 1, 4'h0, 14'd16, 32'h0, 32'h0};
    v[14] = '{1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'hCAFEF00D, 32'h0};
    v[15] = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 0, 0, 1, 1, 4'h0, 14'd4, 32'h0, 32'h0};
    v[16] = '{1, 2'd1, 0, 3'd2, 32'h10, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'h1234BEEE, 32'h0};
    v[17] = '{1, 2'd2, 1, 3'd2, 32'h50, 32'h0, 0, 1, 0, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[18] = '{0, 2'd2, 0, 3'd2, 32'h50, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};
    v[19] = '{0, 2'd0, 0, 3'd0, 32'h00, 32'h0, 1, 1, 0, 0, 1, 4'h0, 14'd0, 32'h0, 32'h0};

    repeat (2) @(posedge clk);
    #1 check("reset_outputs", outs(ram_addr), {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 14'd0, 32'h0, 32'h0});
    @(posedge clk); #1 resetn = 1;

    // Address is only meaningful while a strobe is expected.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(v[i].hsel, v[i].htrans, v[i].hwrite, v[i].hsize, v[i].haddr, v[i].hwdata, v[i].hreadyin);
      @(negedge clk);
      check($sformatf("row%0d", i), outs(v[i].e_en ? ram_addr : 14'd0),
            {v[i].e_rdy, v[i].e_resp, v[i].e_en, v[i].e_rwn, v[i].e_wben, v[i].e_addr, v[i].e_rdata, v[i].e_wdata});
    end

    @(posedge clk); #1 drive(1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 1);
    @(posedge clk); #1 drive(0, 2'd0, 0, 3'd0, 32'h0, 32'h0, 1);
    @(negedge clk);
    check("rd1_before_reset", outs(ram_addr), {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 14'd4, 32'h0, 32'h0});
    #1 resetn = 0;
    #1 check("reset_mid_rd1", outs(ram_addr), {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 14'd0, 32'h0, 32'h0});
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    check("idle_after_reset", outs(ram_addr), {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 14'd0, 32'h0, 32'h0});

    @(posedge clk); #1 drive(1, 2'd2, 1, 3'd2, 32'h14, 32'h0, 1);
    @(posedge clk); #1 drive(1, 2'd2, 0, 3'd2, 32'h14, 32'h55, 0);
    @(negedge clk);
    check("wr_stalled_bus", outs(ram_addr), {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 14'd5, 32'h0, 32'h55});
    @(posedge clk); #1 drive(0, 2'd0, 0, 3'd0, 32'h0, 32'h0, 1);
    @(negedge clk);
    check("idle_after_stall", outs(14'd0), {1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 14'd0, 32'h0, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
